// File: rtl/cmd_sched_pkg.sv
// Shared types and constants for the time-ordered command scheduler.
package cmd_sched_pkg;

    localparam int unsigned CLK_PER_US   = 48;
    localparam int unsigned LEAD_DEFAULT = 8 * CLK_PER_US;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StIssue,
        StClear
    } sched_state_e;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] freq_step;
        logic [31:0] freq_rate;
        logic [15:0] n_impulse;
        logic [1:0]  cmd_type;
        logic [31:0] interval_ti;
        logic [31:0] interval_tp;
        logic [31:0] tblank1;
        logic [31:0] tblank2;
    } cmd_payload_t;

    localparam int unsigned PAYLOAD_W = $bits(cmd_payload_t);

endpackage

// File: rtl/cmd_slot_alloc.sv
// Free-slot finder: lowest index whose valid bit is clear.
module cmd_slot_alloc
    import cmd_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid,
    output logic [AW-1:0]    free_idx,
    output logic             free_found
);

    // Walk downwards so the last hit (lowest index) wins.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx   = AW'(i);
                free_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_time_sched.sv
// Time-ordered command scheduler: buffers timed commands and presents the earliest
// one LEAD clocks ahead of its start time, purging stale entries along the way.
module cmd_time_sched
    import cmd_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned TW    = 64,
    parameter int unsigned PW    = PAYLOAD_W,
    parameter int unsigned LEAD  = LEAD_DEFAULT
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic [TW-1:0] TIME,
    input  logic          TIME_UPD,
    input  logic          FLUSH,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [TW-1:0] IN_TIME,
    input  logic [PW-1:0] IN_PAYLOAD,
    output logic          OUT_VALID,
    output logic          OUT_STB,
    input  logic          OUT_ACK,
    output logic [TW-1:0] OUT_TIME,
    output logic [PW-1:0] OUT_PAYLOAD,
    output logic [AW:0]   FILL,
    output logic          FULL,
    output logic          OVF,
    output logic [15:0]   DROP_CNT
);

    localparam logic [AW:0]   FillOne  = (AW+1)'(1);
    localparam logic [AW:0]   FillMax  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] IdxLast  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] IdxOne   = AW'(1);
    localparam logic [TW:0]   LeadWide = (TW+1)'(LEAD);

    sched_state_e state_q, state_d;

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [TW-1:0]    slot_time_q [DEPTH];
    logic [PW-1:0]    slot_pay_q  [DEPTH];

    logic [AW:0]   fill_q, fill_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d, drop_inc;
    logic          best_vld_q, best_vld_d;
    logic [AW-1:0] best_idx_q, best_idx_d;
    logic [TW-1:0] best_time_q, best_time_d;
    logic [AW-1:0] scan_idx_q, scan_idx_d;
    logic          pend_q, pend_d;
    logic          upd_q;
    logic          out_vld_q, out_vld_d;
    logic          out_stb_q, out_stb_d;
    logic [TW-1:0] out_time_q, out_time_d;
    logic [PW-1:0] out_pay_q, out_pay_d;

    logic          wr_en;
    logic [AW-1:0] free_idx;
    logic          free_found;
    logic          upd_edge;
    logic          issue_due;
    logic [TW-1:0] scan_time;

    cmd_slot_alloc #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_alloc (
        .valid      (vld_q),
        .free_idx   (free_idx),
        .free_found (free_found)
    );

    assign upd_edge  = TIME_UPD & ~upd_q;
    assign drop_inc  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
    // Widened so TIME near the top of its range cannot wrap past the command time.
    assign issue_due = ({1'b0, TIME} + LeadWide) >= {1'b0, best_time_q};
    assign scan_time = slot_time_q[scan_idx_q];

    always_comb begin
        state_d     = state_q;
        vld_d       = vld_q;
        fill_d      = fill_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        best_vld_d  = best_vld_q;
        best_idx_d  = best_idx_q;
        best_time_d = best_time_q;
        scan_idx_d  = scan_idx_q;
        pend_d      = pend_q;
        out_vld_d   = out_vld_q;
        out_stb_d   = 1'b0;
        out_time_d  = out_time_q;
        out_pay_d   = out_pay_q;
        wr_en       = 1'b0;

        if (out_vld_q && OUT_ACK) begin
            out_vld_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (FLUSH) begin
                    state_d = StClear;
                end else if (IN_VALID) begin
                    if (free_found) begin
                        wr_en           = 1'b1;
                        vld_d[free_idx] = 1'b1;
                        fill_d          = fill_q + FillOne;
                        state_d         = StScan;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (upd_edge || pend_q) begin
                    state_d = StScan;
                end else if (best_vld_q && (best_time_q <= TIME)) begin
                    // Late while the consumer still holds the previous command.
                    vld_d[best_idx_q] = 1'b0;
                    fill_d            = fill_q - FillOne;
                    drop_d            = drop_inc;
                    state_d           = StScan;
                end else if (best_vld_q && !out_vld_q && issue_due) begin
                    state_d = StIssue;
                end
            end

            StScan: begin
                if (FLUSH) begin
                    state_d = StClear;
                end else begin
                    if (upd_edge) begin
                        pend_d = 1'b1;
                    end
                    if (vld_q[scan_idx_q]) begin
                        if (scan_time <= TIME) begin
                            vld_d[scan_idx_q] = 1'b0;
                            fill_d            = fill_q - FillOne;
                            drop_d            = drop_inc;
                        end else if (!best_vld_q || (scan_time < best_time_q)) begin
                            best_vld_d  = 1'b1;
                            best_idx_d  = scan_idx_q;
                            best_time_d = scan_time;
                        end
                    end
                    if (scan_idx_q == IdxLast) begin
                        state_d = StIdle;
                    end else begin
                        scan_idx_d = scan_idx_q + IdxOne;
                    end
                end
            end

            StIssue: begin
                if (FLUSH) begin
                    state_d = StClear;
                end else begin
                    if (upd_edge) begin
                        pend_d = 1'b1;
                    end
                    out_time_d        = slot_time_q[best_idx_q];
                    out_pay_d         = slot_pay_q[best_idx_q];
                    out_vld_d         = 1'b1;
                    out_stb_d         = 1'b1;
                    vld_d[best_idx_q] = 1'b0;
                    fill_d            = fill_q - FillOne;
                    best_vld_d        = 1'b0;
                    state_d           = StScan;
                end
            end

            StClear: begin
                vld_d      = '0;
                fill_d     = '0;
                best_vld_d = 1'b0;
                out_vld_d  = 1'b0;
                ovf_d      = 1'b0;
                drop_d     = '0;
                pend_d     = 1'b0;
                state_d    = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Every scan starts from slot 0 with a fresh best candidate.
        if ((state_d == StScan) && (state_q != StScan)) begin
            scan_idx_d = '0;
            best_vld_d = 1'b0;
            pend_d     = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            vld_q       <= '0;
            fill_q      <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
            best_vld_q  <= 1'b0;
            best_idx_q  <= '0;
            best_time_q <= '0;
            scan_idx_q  <= '0;
            pend_q      <= 1'b0;
            upd_q       <= 1'b0;
            out_vld_q   <= 1'b0;
            out_stb_q   <= 1'b0;
            out_time_q  <= '0;
            out_pay_q   <= '0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            fill_q      <= fill_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            best_vld_q  <= best_vld_d;
            best_idx_q  <= best_idx_d;
            best_time_q <= best_time_d;
            scan_idx_q  <= scan_idx_d;
            pend_q      <= pend_d;
            upd_q       <= TIME_UPD;
            out_vld_q   <= out_vld_d;
            out_stb_q   <= out_stb_d;
            out_time_q  <= out_time_d;
            out_pay_q   <= out_pay_d;
        end
    end

    // Slot contents are qualified by vld_q, so they need no reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            slot_time_q[free_idx] <= IN_TIME;
            slot_pay_q[free_idx]  <= IN_PAYLOAD;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst_n) begin
            fill_matches_valid: assert (fill_q == (AW+1)'($countones(vld_q)));
        end
    end

    assign IN_READY    = (state_q == StIdle);
    assign OUT_VALID   = out_vld_q;
    assign OUT_STB     = out_stb_q;
    assign OUT_TIME    = out_time_q;
    assign OUT_PAYLOAD = out_pay_q;
    assign FILL        = fill_q;
    assign FULL        = (fill_q == FillMax);
    assign OVF         = ovf_q;
    assign DROP_CNT    = drop_q;

endmodule

// File: doc/cmd_time_sched.md
Name: cmd_time_sched

Overview:
Parametrised time-ordered command scheduler. It buffers timed commands written from the MCU/SPI side into an internal slot register array. It tracks the earliest still-valid command and presents it to the synchronisation/execution block LEAD clocks before its start time, using a hold-until-ACK handshake. Stale commands are purged, and overflow, drop and fill status are exported. It sits between the SPI command decoder and the sync block.

Parameters:
DEPTH, 16, number of command slots; must be a power of 2 and at least 2.
AW, $clog2(DEPTH), slot index width (derived).
TW, 64, system time width.
PW, 274, payload width (cmd_sched_pkg::cmd_payload_t).
LEAD, 384, issue lead in clocks (8 us at 48 MHz).

Ports:
CLK  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
TIME  in  TW  current system time, +1 per clock except on jumps.
TIME_UPD  in  1  system time was reloaded; level or pulse, rising edge detected.
FLUSH  in  1  one-cycle pulse: discard all commands.
IN_VALID  in  1  command write request.
IN_READY  out  1  write accepted this cycle when IN_VALID and IN_READY are both high.
IN_TIME  in  TW  command start time.
IN_PAYLOAD  in  PW  command body.
OUT_VALID  out  1  command presented; held until OUT_ACK.
OUT_STB  out  1  one-cycle strobe on the cycle OUT_VALID rises (DATA_WR-compatible).
OUT_ACK  in  1  consumer took the command.
OUT_TIME  out  TW  presented start time.
OUT_PAYLOAD  out  PW  presented body.
FILL  out  AW+1  number of occupied slots.
FULL  out  1  FILL==DEPTH.
OVF  out  1  sticky: a write was dropped because the buffer was full.
DROP_CNT  out  16  saturating count of purged stale commands.

Behaviour:
- Reset (asynchronous): all slot valid bits 0; BEST_VLD 0; state IDLE; all outputs 0 (IN_READY follows state, so it is 1 after reset). A reset mid-scan or mid-present abandons the operation.
- Storage: valid[DEPTH], time[DEPTH], payload[DEPTH] in flops; combinational read.
- States: IDLE, SCAN, ISSUE, CLEAR.
- IN_READY is 1 only in IDLE. It is 0 in SCAN, ISSUE and CLEAR; upstream holds IN_VALID. Worst-case stall is DEPTH+2 cycles.
- IDLE priority, highest first: FLUSH, accepted write, pending rescan (TIME_UPD edge or pending flag), late check, issue check.
- Write in IDLE: slot = lowest free index. valid set, time and payload stored, FILL+1, then go to SCAN.
- Write while FULL: the handshake completes, the data is dropped, OVF is set, and there is no state change.
- SCAN runs for DEPTH cycles, slot i on cycle i, then returns to IDLE.
  - A valid slot with time<=TIME is purged: valid cleared, FILL-1, DROP_CNT+1 saturating at 16'hFFFF.
  - Otherwise, if time<BEST_TIME, or BEST_VLD was 0 in this scan, record BEST_IDX/BEST_TIME. Ties go to the lower index.
  - BEST_VLD is cleared at scan start and valid at scan end.
- A TIME_UPD edge seen during SCAN or ISSUE sets a pending flag, which forces a new SCAN on return to IDLE. The flag clears at SCAN start.
- Late check (IDLE, BEST_VLD, BEST_TIME<=TIME): this is reachable while OUT_VALID blocks issue. The best slot is purged, DROP_CNT+1, then go to SCAN.
- Issue check (IDLE, BEST_VLD, !OUT_VALID, TIME+LEAD>=BEST_TIME, compared in TW+1 bits): go to ISSUE.
- ISSUE is one cycle:
  - OUT_TIME/OUT_PAYLOAD are loaded from BEST_IDX.
  - OUT_VALID is set; OUT_STB=1 for this cycle.
  - The slot is freed (FILL-1) and BEST_VLD cleared; next state is SCAN.
- OUT_ACK while OUT_VALID: OUT_VALID drops the next cycle, in any state. OUT_ACK without OUT_VALID is ignored. OUT_TIME/OUT_PAYLOAD keep their last value.
- FLUSH, from any state: CLEAR for one cycle.
  - All valid bits, BEST_VLD, OUT_VALID, OVF, DROP_CNT and the pending flag are cleared; FILL becomes 0.
  - Next state is IDLE.
- FILL is maintained as a counter and must always equal the popcount of valid (assertion).

Decomposition:
- cmd_sched_pkg holds:
  - the state enum;
  - cmd_payload_t, a packed struct of FREQ 48, FREQ_STEP 48, FREQ_RATE 32, N_impulse 16, TYPE 2, Interval_Ti 32, Interval_Tp 32, Tblank1 32 and Tblank2 32, totalling 274 bits;
  - CLK_PER_US=48 and the default LEAD.
- Sub-module cmd_slot_alloc: a valid vector goes in; the lowest free index and a free-found flag come out (combinational priority encoder).

Test Plan:
(Bench uses DEPTH=4, LEAD=8, TIME counting from 0.)
1. Order: write times 100, 50, 200 near TIME=0. OUT_STB must fire at TIME 42, then 92, then 192 (each within the DEPTH+3-cycle scan/issue latency), with OUT_TIME 50, 100, 200. ACK each 3 cycles after OUT_VALID.
2. Overflow: write 5 commands with times 1000..1004. Expect FILL=4, FULL=1, OVF=1, and slot contents unchanged. FLUSH then gives FILL=0 and OVF=0.
3. Stale: at TIME=20, write time 10. After the scan, DROP_CNT=1, FILL=0, and OUT_VALID is never asserted.
4. Time jump: commands at 500 and 1000. TIME jumps 0->600 with TIME_UPD. The 500 command is purged (DROP_CNT=1); 1000 is issued at TIME 992.
5. Tie/hold: slots 0 and 2 both at time 300, ACK withheld until TIME 310. Slot 0 issues at 292. The slot 2 command is purged as late (DROP_CNT=1) and OUT_VALID stays with slot 0 data until the ACK.
6. Reset and flush: FLUSH mid-SCAN, then assert rst_n low while OUT_VALID=1. All outputs return to 0 asynchronously; IN_READY=1 on the first clock after release.
